// File: rtl/accbuf_drain.sv
// accbuf_drain: reader side of a measurement accumulator buffer.
// Pulls complete x/y word pairs out of the dpram as the writer lands them.
// Each pair goes out as one {y,x} beat on a valid/ready stream, with m_last on the final pair.
module accbuf_drain #(
  parameter int DW     = 32,
  parameter int AW     = 12,
  parameter int RDLAT  = 2,
  parameter int FDEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [AW-2:0]   npairs,
  input  logic [AW:0]     wr_addr,
  output logic [AW-1:0]   rd_addr,
  output logic            rd_en,
  input  logic [DW-1:0]   rd_data,
  output logic [2*DW-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            done,
  output logic            ovf
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW:0] TWO_WORDS = 2;

  typedef enum logic [2:0] {IDLE, RUN, RD_X, RD_Y, DRAIN} state_t;

  state_t state, state_next;

  logic [AW:0]     rp;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   issued;
  logic [AW-1:0]   npairs_r;
  logic [CW-1:0]   cr;
  logic [CW-1:0]   fcount;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [2*DW-1:0] fmem [FDEPTH];
  logic [RDLAT-1:0] tag_v;
  logic [RDLAT-1:0] tag_y;
  logic [DW-1:0]   x_hold;

  logic [AW:0]     rp_eff;
  logic            avail;
  logic            eligible;
  logic            ovf_set;
  logic            rd_start;
  logic            accept;
  logic            out_free;
  logic            push;
  logic            pop;
  logic            bypass;
  logic            fifo_wr;
  logic            drain_done;
  logic [2*DW-1:0] push_data;

  // In RD_Y the odd word is being issued now, so look one word ahead for back-to-back pairs.
  assign rp_eff     = (state == RD_Y) ? rp + 1'b1 : rp;
  assign avail      = (wr_addr >= rp_eff) && ((wr_addr - rp_eff) >= TWO_WORDS);
  assign eligible   = avail && (cr != '0) && (issued < npairs_r);
  assign ovf_set    = !start && (wr_addr < rp);
  assign rd_start   = (state_next == RD_X);
  assign accept     = m_valid && m_ready;
  assign out_free   = !m_valid || m_ready;
  assign push       = tag_v[RDLAT-1] && tag_y[RDLAT-1];
  assign push_data  = {rd_data, x_hold};
  assign pop        = out_free && (fcount != '0);
  assign bypass     = out_free && (fcount == '0) && push;
  assign fifo_wr    = push && !bypass;
  assign drain_done = (pc == npairs_r) && !m_valid && (fcount == '0);
  assign m_last     = m_valid && (pc == npairs_r - 1'b1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decision: start wins, then an overflow aborts, then normal pair sequencing.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else if (ovf_set) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (eligible) state_next = RD_X;
        RD_X:    state_next = RD_Y;
        RD_Y: begin
          if (issued == npairs_r) state_next = DRAIN;
          else if (eligible)      state_next = RD_X;
          else                    state_next = RUN;
        end
        DRAIN:   if (drain_done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Read port drive: one word per clock while in the two read states.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if ((state == RD_X) || (state == RD_Y)) begin
      rd_en   = 1'b1;
      rd_addr = rp[AW-1:0];
    end
  end

  // Run bookkeeping: pointers, pair counts, credits and the done/ovf flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rp       <= '0;
      pc       <= '0;
      issued   <= '0;
      npairs_r <= '0;
      cr       <= CW'(FDEPTH);
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else if (start) begin
      rp       <= '0;
      pc       <= '0;
      issued   <= '0;
      npairs_r <= (npairs == '0) ? {1'b1, {(AW-1){1'b0}}} : {1'b0, npairs};
      cr       <= CW'(FDEPTH);
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (rd_en)    rp     <= rp + 1'b1;
      if (rd_start) issued <= issued + 1'b1;
      if (accept)   pc     <= pc + 1'b1;
      case ({rd_start, accept})
        2'b10:   cr <= cr - 1'b1;
        2'b01:   cr <= cr + 1'b1;
        default: cr <= cr;
      endcase
      if (ovf_set) ovf <= 1'b1;
      if ((state == DRAIN) && drain_done && !ovf_set) done <= 1'b1;
    end
  end

  // Return path: tags follow each read through the dpram latency; x waits for its y.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v  <= '0;
      tag_y  <= '0;
      x_hold <= '0;
    end else if (start) begin
      tag_v  <= '0;
      tag_y  <= '0;
      x_hold <= '0;
    end else begin
      tag_v[0] <= rd_en;
      tag_y[0] <= (state == RD_Y);
      for (int i = 1; i < RDLAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_y[i] <= tag_y[i-1];
      end
      if (tag_v[RDLAT-1] && !tag_y[RDLAT-1]) x_hold <= rd_data;
    end
  end

  // Pair FIFO with a registered output stage; an empty FIFO lets a fresh pair go straight out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FDEPTH; i++) fmem[i] <= '0;
      wptr    <= '0;
      rptr    <= '0;
      fcount  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (start) begin
      wptr    <= '0;
      rptr    <= '0;
      fcount  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (fifo_wr) begin
        fmem[wptr] <= push_data;
        wptr       <= wptr + 1'b1;
      end
      if (pop) begin
        m_data  <= fmem[rptr];
        m_valid <= 1'b1;
        rptr    <= rptr + 1'b1;
      end else if (bypass) begin
        m_data  <= push_data;
        m_valid <= 1'b1;
      end else if (out_free) begin
        m_valid <= 1'b0;
      end
      case ({fifo_wr, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
    end
  end

endmodule

// File: tb/tb_accbuf_drain.sv
// tb_accbuf_drain: drives a writer and a 2-cycle dpram model around accbuf_drain.
// Expected pairs are rebuilt from the memory image: pair k = {mem[2k+1], mem[2k]}.
module tb_accbuf_drain;

  localparam int DW     = 32;
  localparam int AW     = 12;
  localparam int RDLAT  = 2;
  localparam int FDEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [AW-2:0]   npairs = '0;
  logic [AW:0]     wr_addr = '0;
  logic [AW-1:0]   rd_addr;
  logic            rd_en;
  logic [DW-1:0]   rd_data = '0;
  logic [2*DW-1:0] m_data;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic            m_last;
  logic            done;
  logic            ovf;

  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0]   pipe_addr = '0;

  int  n_checks = 0;
  int  n_fails = 0;
  int  accept_count = 0;
  int  rd_count = 0;
  int  exp_n = 0;
  int  wr_target = 0;
  int  wr_rate = 100;
  int  rdy_rate = 100;
  int  saved;
  bit  mon_en = 1'b0;

  always #5 clk = ~clk;

  accbuf_drain #(.DW(DW), .AW(AW), .RDLAT(RDLAT), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .npairs(npairs), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .done(done), .ovf(ovf)
  );

  // dpram read port: address registered, then data registered (2 clocks from rd_en)
  always @(posedge clk) begin
    pipe_addr <= rd_addr;
    rd_data   <= mem[pipe_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // stream scoreboard: every presented pair must equal the next expected pair of this run
  always @(negedge clk) begin
    if (rd_en) rd_count++;
    if (mon_en && reset_n) begin
      if (m_valid) begin
        checkOutput("m_data", m_data, {mem[2*accept_count+1], mem[2*accept_count]});
        checkOutput("m_last", 64'(m_last), 64'(accept_count == exp_n - 1));
        if (m_ready) accept_count++;
      end else begin
        checkOutput("m_last_idle", 64'(m_last), 64'd0);
      end
    end
  end

  // one clock of writer pacing and consumer readiness
  task automatic applyStimulus();
    @(posedge clk); #1;
    if ((int'(wr_addr) < wr_target) && (int'($urandom_range(0, 99)) < wr_rate)) begin
      mem[wr_addr[AW-1:0]] = $urandom;
      wr_addr = wr_addr + 1'b1;
    end
    m_ready = (int'($urandom_range(0, 99)) < rdy_rate);
  endtask

  task automatic startRun(input int n);
    @(posedge clk); #1;
    mon_en = 1'b0;
    start = 1'b1;
    npairs = (AW-1)'(n);
    wr_addr = '0;
    wr_target = 0;
    exp_n = (n == 0) ? (1 << (AW-1)) : n;
    accept_count = 0;
    @(posedge clk); #1;
    start = 1'b0;
    rd_count = 0;
    mon_en = 1'b1;
  endtask

  task automatic finishRun(input int limit, input bit check_early);
    int i;
    i = 0;
    while ((accept_count < exp_n) && (i < limit)) begin
      applyStimulus();
      i++;
    end
    checkOutput("accept_all", 64'(accept_count), 64'(exp_n));
    if (check_early) checkOutput("done_early", 64'(done), 64'd0);
    applyStimulus();
    checkOutput("done", 64'(done), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rd_en", 64'(rd_en), 64'd0);
    checkOutput("rst_rd_addr", 64'(rd_addr), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_m_last", 64'(m_last), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    reset_n = 1'b1;

    // 1: three pairs at full rate
    $display("[TB] step 1: three pairs, full rate");
    startRun(3);
    wr_target = 6; wr_rate = 100; rdy_rate = 100;
    finishRun(200, 1'b1);

    // 2: consumer stalled; credits cap outstanding pairs
    $display("[TB] step 2: backpressure");
    startRun(8);
    wr_target = 16; rdy_rate = 0;
    repeat (20) applyStimulus();
    checkOutput("bp_reads_capped", 64'(rd_count <= 2 * FDEPTH), 64'd1);
    checkOutput("bp_valid_held", 64'(m_valid), 64'd1);
    checkOutput("bp_none_taken", 64'(accept_count), 64'd0);
    rdy_rate = 60;
    finishRun(400, 1'b0);

    // 3: lone x word must not trigger a read; y completes it with fixed latency
    $display("[TB] step 3: half pair then latency");
    startRun(2);
    wr_target = 1; rdy_rate = 100;
    repeat (10) applyStimulus();
    checkOutput("half_no_read", 64'(rd_count), 64'd0);
    checkOutput("half_no_valid", 64'(m_valid), 64'd0);
    wr_target = 2;
    repeat (5) applyStimulus();
    checkOutput("lat_before", 64'(m_valid), 64'd0);
    applyStimulus();
    checkOutput("lat_at", 64'(m_valid), 64'd1);
    wr_target = 4;
    finishRun(200, 1'b0);

    // 4: npairs=0 means the whole buffer
    $display("[TB] step 4: full buffer");
    startRun(0);
    wr_target = 1 << AW; rdy_rate = 80;
    finishRun(20000, 1'b0);
    checkOutput("full_words_read", 64'(rd_count), 64'(1 << AW));

    // 5: restart while pairs are queued and reads are in flight
    $display("[TB] step 5: restart mid-run");
    startRun(8);
    wr_target = 16; rdy_rate = 0;
    for (int i = 0; (i < 50) && (rd_count < 6); i++) applyStimulus();
    checkOutput("restart_reads_issued", 64'(rd_count >= 6), 64'd1);
    startRun(4);
    checkOutput("restart_valid_low", 64'(m_valid), 64'd0);
    checkOutput("restart_ovf", 64'(ovf), 64'd0);
    wr_target = 8; rdy_rate = 100;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (rd_en) break;
    end
    checkOutput("restart_first_rd", 64'(rd_en), 64'd1);
    checkOutput("restart_first_addr", 64'(rd_addr), 64'd0);
    finishRun(200, 1'b0);

    // 6a: asynchronous reset in the middle of a y read
    $display("[TB] step 6: async reset and overflow");
    startRun(4);
    wr_target = 8; rdy_rate = 100;
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      if (rd_en && (rd_addr == 12'd7)) break;
    end
    checkOutput("ar_in_rd_y", 64'(rd_en && (rd_addr == 12'd7)), 64'd1);
    #2;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_rd_en", 64'(rd_en), 64'd0);
    checkOutput("ar_rd_addr", 64'(rd_addr), 64'd0);
    checkOutput("ar_m_valid", 64'(m_valid), 64'd0);
    checkOutput("ar_m_data", m_data, 64'd0);
    checkOutput("ar_m_last", 64'(m_last), 64'd0);
    checkOutput("ar_done", 64'(done), 64'd0);
    checkOutput("ar_ovf", 64'(ovf), 64'd0);
    reset_n = 1'b1;

    // 6b: writer address jumps backwards without start
    startRun(8);
    wr_target = 8; rdy_rate = 100;
    for (int i = 0; (i < 60) && (rd_count < 8); i++) applyStimulus();
    repeat (6) applyStimulus();
    checkOutput("ovf_pre_reads", 64'(rd_count), 64'd8);
    checkOutput("ovf_pre_accepts", 64'(accept_count), 64'd4);
    checkOutput("ovf_pre_flag", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    wr_addr = 13'd2;
    wr_target = 16;
    applyStimulus();
    checkOutput("ovf_set", 64'(ovf), 64'd1);
    saved = rd_count;
    repeat (20) applyStimulus();
    checkOutput("ovf_reads_stopped", 64'(rd_count), 64'(saved));
    checkOutput("ovf_sticky", 64'(ovf), 64'd1);
    checkOutput("ovf_no_done", 64'(done), 64'd0);
    startRun(1);
    checkOutput("ovf_cleared", 64'(ovf), 64'd0);
    checkOutput("ovf_done_cleared", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
